// File: rtl/pio_input_conditioner.sv
// Synchronizes, debounces and edge-detects one raw board input for an Avalon PIO.
// Define PIO_INPUT_GLITCH_COUNT_EN to add the saturating glitch_count output.
module pio_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_W           = 16,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       raw_in,
    input  logic       ack,
    output logic       level_out,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       event_flag,
    output logic [7:0] event_count
`ifdef PIO_INPUT_GLITCH_COUNT_EN
    ,
    output logic [7:0] glitch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE_LOW   = 2'd0,
        CHECK_HIGH = 2'd1,
        IDLE_HIGH  = 2'd2,
        CHECK_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LP_DEB = CNT_W'(DEBOUNCE_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_s;
    logic             w_rise;
    logic             w_fall;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             r_flag;
    logic [7:0]       r_count;

    assign w_s = r_sync2 ^ ACTIVE_LOW;

    // Sync flops reset to the inactive raw level so release never looks like an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= raw_in;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        unique case (r_state)
            IDLE_LOW: begin
                if (w_s) begin
                    w_state_nxt = CHECK_HIGH;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            CHECK_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_DEB) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                    w_rise      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!w_s) begin
                    w_state_nxt = CHECK_LOW;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            CHECK_LOW: begin
                if (w_s) begin
                    w_state_nxt = IDLE_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == LP_DEB) begin
                    w_state_nxt = IDLE_LOW;
                    w_cnt_nxt   = '0;
                    w_fall      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= w_rise;
            r_fall <= w_fall;
            if (w_rise) begin
                r_level <= 1'b1;
            end else if (w_fall) begin
                r_level <= 1'b0;
            end
        end
    end

    // Flag and counter follow the visible rise pulse, so an ack seen during it loses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flag  <= 1'b0;
            r_count <= 8'd0;
        end else begin
            if (r_rise) begin
                r_flag  <= 1'b1;
                r_count <= r_count + 8'd1;
            end else if (ack) begin
                r_flag <= 1'b0;
            end
        end
    end

`ifdef PIO_INPUT_GLITCH_COUNT_EN
    logic       w_abort;
    logic [7:0] r_glitch;

    assign w_abort = ((r_state == CHECK_HIGH) && !w_s) ||
                     ((r_state == CHECK_LOW) && w_s);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_glitch <= 8'd0;
        end else if (ack) begin
            r_glitch <= 8'd0;
        end else if (w_abort && (r_glitch != 8'hFF)) begin
            r_glitch <= r_glitch + 8'd1;
        end
    end

    assign glitch_count = r_glitch;
`endif

    assign level_out   = r_level;
    assign rise_pulse  = r_rise;
    assign fall_pulse  = r_fall;
    assign event_flag  = r_flag;
    assign event_count = r_count;

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Bench for pio_input_conditioner: vector table, directed corner sequences
// and randomized bounce traffic checked against a run-length reference model.
module tb_pio_input_conditioner;

    localparam int D = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;
    logic       raw_in  = 1'b0;
    logic       ack     = 1'b0;
    logic       raw_in2 = 1'b1;
    logic       ack2    = 1'b0;
    logic       level_out, rise_pulse, fall_pulse, event_flag;
    logic [7:0] event_count;
    logic       level2, rise2, fall2, flag2;
    logic [7:0] count2;
`ifdef PIO_INPUT_GLITCH_COUNT_EN
    logic [7:0] glitch_count, glitch2;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pio_input_conditioner #(
        .DEBOUNCE_CYCLES(D), .CNT_W(16), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in), .ack(ack),
        .level_out(level_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .event_flag(event_flag),
        .event_count(event_count)
`ifdef PIO_INPUT_GLITCH_COUNT_EN
        , .glitch_count(glitch_count)
`endif
    );

    pio_input_conditioner #(
        .DEBOUNCE_CYCLES(D), .CNT_W(16), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .reset_n(reset_n), .raw_in(raw_in2), .ack(ack2),
        .level_out(level2), .rise_pulse(rise2),
        .fall_pulse(fall2), .event_flag(flag2),
        .event_count(count2)
`ifdef PIO_INPUT_GLITCH_COUNT_EN
        , .glitch_count(glitch2)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a level change is accepted once the twice-delayed
    // input has disagreed with the current level for D+1 consecutive edges.
    bit m_h1, m_h2, m_level, m_rise, m_fall, m_flag;
    int m_run, m_count, m_glitch;

    task automatic model_reset();
        m_h1 = 0; m_h2 = 0; m_level = 0; m_rise = 0; m_fall = 0;
        m_flag = 0; m_run = 0; m_count = 0; m_glitch = 0;
    endtask

    task automatic model_step(input bit raw, input bit a);
        bit s;
        s = m_h2;
        m_h2 = m_h1;
        m_h1 = raw;
        m_flag = m_rise ? 1'b1 : (a ? 1'b0 : m_flag);
        m_count = (m_count + int'(m_rise)) % 256;
        if (a) m_glitch = 0;
        else if (s == m_level && m_run > 0 && m_glitch < 255) m_glitch++;
        m_rise = 0;
        m_fall = 0;
        if (s != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_level = s;
                m_rise = s;
                m_fall = !s;
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit raw, input bit a);
        raw_in = raw;
        ack = a;
        @(posedge clk);
        model_step(raw, a);
        @(negedge clk);
        check("model", {level_out, rise_pulse, fall_pulse, event_flag, event_count},
              {m_level, m_rise, m_fall, m_flag, 8'(m_count)});
`ifdef PIO_INPUT_GLITCH_COUNT_EN
        check("glitch", glitch_count, 8'(m_glitch));
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        raw_in = 0;
        ack = 0;
        reset_n = 0;
        model_reset();
        @(negedge clk);
        reset_n = 1;
    endtask

    typedef struct {
        bit         raw;
        bit         ack;
        bit         lvl;
        bit         rise;
        bit         fall;
        bit         flag;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[32];
    int   n;

    initial begin
        for (int i = 0; i < 32; i++) begin
            tbl[i] = '{raw: (i < 10) || (i >= 20 && i < 23), ack: (i == 30),
                       lvl: (i >= 6 && i < 16), rise: (i == 6), fall: (i == 16),
                       flag: (i >= 7 && i < 30), cnt: (i >= 7) ? 8'd1 : 8'd0};
        end
        model_reset();
        #1 reset_n = 0;
        #1;
        check("reset_outs", {level_out, rise_pulse, fall_pulse, event_flag, event_count}, 0);
        check("reset_outs_al", {level2, rise2, fall2, flag2, count2}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1;

        // rise, fall, bounce and ack on the ACTIVE_LOW=0 instance
        for (int i = 0; i < 32; i++) begin
            tick(tbl[i].raw, tbl[i].ack);
            check($sformatf("vec%0d", i),
                  {level_out, rise_pulse, fall_pulse, event_flag, event_count},
                  {tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].flag, tbl[i].cnt});
            check("al_idle", {level2, rise2, fall2, flag2, count2}, 0);
`ifdef PIO_INPUT_GLITCH_COUNT_EN
            check("al_glitch", glitch2, 0);
`endif
        end

        // active-low instance: assert by driving the pin low
        raw_in2 = 0;
        for (n = 1; n <= 20; n++) begin
            tick(0, 0);
            if (level2) break;
        end
        check("al_latency", n, D + 3);
        check("al_rise", rise2, 1);

        // randomized bounce traffic
        for (int i = 0; i < 400; i++) begin
            automatic bit v = 1'($urandom_range(0, 1));
            automatic int len = $urandom_range(1, 10);
            repeat (len) tick(v, $urandom_range(0, 15) == 0);
        end

        // reset two cycles into CHECK_HIGH, with flag and count nonzero
        do_reset();
        repeat (8) tick(1, 0);
        repeat (8) tick(0, 0);
        repeat (4) tick(1, 0);
        #2 reset_n = 0;
        #1;
        check("async_reset", {level_out, rise_pulse, fall_pulse, event_flag, event_count}, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        for (n = 1; n <= 20; n++) begin
            tick(1, 0);
            if (rise_pulse) break;
        end
        check("post_reset_latency", n, D + 3);

        // 256 clean presses wrap the counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            repeat (7) tick(1, 0);
            repeat (7) tick(0, 0);
        end
        check("wrap_count", event_count, 0);
        check("wrap_flag", event_flag, 1);
        repeat (7) tick(1, 0);
        check("rise257", rise_pulse, 1);
        tick(1, 1);
        check("ack_vs_set", event_flag, 1);
        check("count257", event_count, 1);
        tick(1, 1);
        check("ack_clear", event_flag, 0);
        tick(1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
